// File: rtl/morse_scheduler.sv
// Element-timing controller: pops one character from the show-ahead FIFO and
// sequences dots, dashes and symbol/letter/word gaps on a single registered key.
module morse_scheduler #(
    parameter int unsigned UNIT_CYCLES = 1_200_000,
    parameter logic [7:0]  ASCII_SPACE = 8'd32
) (
    input  logic       clk_24,
    input  logic       rst,
    input  logic       abort,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    input  logic [6:0] morse_code,
    input  logic [2:0] morse_len,
    output logic       char_rd,
    output logic       key,
    output logic       busy
);

    localparam int unsigned PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MARK,
        S_GAP_SYM,
        S_GAP_CHAR,
        S_GAP_WORD
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_ucnt;
    logic [2:0]      r_idx;
    logic [6:0]      r_code;
    logic [2:0]      r_len;
    logic            r_key;
    logic            r_char_rd;
    logic            r_busy;

    state_t          w_next;
    logic [1:0]      w_units;
    logic            w_latch;
    logic            w_idx_inc;
    logic            w_enter;
    logic            w_tick;
    logic            w_expire;

    assign w_tick   = (r_presc == PW'(UNIT_CYCLES - 1));
    assign w_expire = w_tick && (r_ucnt == 2'd1);

    // Next-state, unit load value and datapath strobes.
    always_comb begin
        w_next    = r_state;
        w_units   = 2'd0;
        w_latch   = 1'b0;
        w_idx_inc = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (char_valid) begin
                    w_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_latch = 1'b1;
                if (char_data == ASCII_SPACE) begin
                    // 4 units loads as 0; the 2-bit counter wraps 0->3->2->1.
                    w_next  = S_GAP_WORD;
                    w_units = 2'd0;
                end else if (morse_len == 3'd0) begin
                    w_next = S_IDLE;
                end else begin
                    w_next  = S_MARK;
                    w_units = morse_code[0] ? 2'd3 : 2'd1;
                end
            end
            S_MARK: begin
                if (w_expire) begin
                    w_idx_inc = 1'b1;
                    if (3'(r_idx + 3'd1) == r_len) begin
                        w_next  = S_GAP_CHAR;
                        w_units = 2'd3;
                    end else begin
                        w_next  = S_GAP_SYM;
                        w_units = 2'd1;
                    end
                end
            end
            S_GAP_SYM: begin
                if (w_expire) begin
                    w_next  = S_MARK;
                    w_units = r_code[r_idx] ? 2'd3 : 2'd1;
                end
            end
            S_GAP_CHAR, S_GAP_WORD: begin
                if (w_expire) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase

        if (abort) begin
            w_next    = S_IDLE;
            w_units   = 2'd0;
            w_latch   = 1'b0;
            w_idx_inc = 1'b0;
        end

        w_enter = (w_next != r_state);
    end

    // State, counters, latches and registered outputs.
    always_ff @(posedge clk_24) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_ucnt    <= 2'd0;
            r_idx     <= 3'd0;
            r_code    <= 7'd0;
            r_len     <= 3'd0;
            r_key     <= 1'b0;
            r_char_rd <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_key     <= (w_next == S_MARK);
            r_char_rd <= (w_next == S_LOOKUP);
            r_busy    <= (w_next != S_IDLE);

            if (w_enter || (r_state == S_IDLE)) begin
                r_presc <= '0;
                r_ucnt  <= w_units;
            end else if (w_tick) begin
                r_presc <= '0;
                r_ucnt  <= r_ucnt - 2'd1;
            end else begin
                r_presc <= PW'(r_presc + 1'b1);
            end

            if (w_latch || abort) begin
                r_idx <= 3'd0;
            end else if (w_idx_inc) begin
                r_idx <= 3'(r_idx + 3'd1);
            end

            if (w_latch) begin
                r_code <= morse_code;
                r_len  <= morse_len;
            end
        end
    end

    assign key     = r_key;
    assign char_rd = r_char_rd;
    assign busy    = r_busy;

endmodule

// File: tb/tb_morse_scheduler.sv
// Directed bench for morse_scheduler with UNIT_CYCLES=4: show-ahead FIFO and
// registered lookup are modelled here; outputs are checked cycle by cycle.
module tb_morse_scheduler;

    logic       clk_24 = 1'b0;
    logic       rst;
    logic       abort;
    logic       char_valid;
    logic [7:0] char_data;
    logic [6:0] morse_code;
    logic [2:0] morse_len;
    logic       char_rd;
    logic       key;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [7:0] fifo_q[$];

    morse_scheduler #(
        .UNIT_CYCLES(4),
        .ASCII_SPACE(8'd32)
    ) dut (
        .clk_24     (clk_24),
        .rst        (rst),
        .abort      (abort),
        .char_valid (char_valid),
        .char_data  (char_data),
        .morse_code (morse_code),
        .morse_len  (morse_len),
        .char_rd    (char_rd),
        .key        (key),
        .busy       (busy)
    );

    always #5 clk_24 = ~clk_24;

    // Lookup model: {len, code}; unknown codes (including space) give len 0.
    function automatic logic [9:0] lut(input logic [7:0] c);
        case (c)
            8'd69:   lut = {3'd1, 7'b0000000};
            8'd65:   lut = {3'd2, 7'b0000010};
            8'd84:   lut = {3'd1, 7'b0000001};
            default: lut = {3'd0, 7'b1111111};
        endcase
    endfunction

    task automatic drive_fifo();
        char_valid = (fifo_q.size() > 0);
        char_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    endtask

    // Advance one cycle; inputs change 1 time unit after the edge.
    task automatic step();
        logic [7:0] d_prev;
        logic       rd_prev;
        d_prev  = char_data;
        rd_prev = char_rd;
        @(posedge clk_24);
        #1;
        {morse_len, morse_code} = lut(d_prev);
        if (rd_prev === 1'b1 && fifo_q.size() > 0) begin
            fifo_q.delete(0);
        end
        drive_fifo();
    endtask

    task automatic check(input string tag, input int cyc, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b0;
        abort      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        morse_code = 7'd0;
        morse_len  = 3'd0;

        // Reset state
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst.key", c, key, 1'b0);
            check("rst.busy", c, busy, 1'b0);
            check("rst.rd", c, char_rd, 1'b0);
        end
        rst = 1'b1;
        step();
        step();

        // 'E': single dot
        fifo_q.push_back(8'd69);
        drive_fifo();
        for (int c = 0; c <= 19; c++) begin
            check("E.key", c, key, (c >= 2 && c <= 5));
            check("E.busy", c, busy, (c >= 1 && c <= 17));
            check("E.rd", c, char_rd, (c == 1));
            step();
        end

        // 'A': dot, symbol gap, dash, letter gap
        fifo_q.push_back(8'd65);
        drive_fifo();
        for (int c = 0; c <= 36; c++) begin
            check("A.key", c, key, ((c >= 2 && c <= 5) || (c >= 10 && c <= 21)));
            check("A.busy", c, busy, (c >= 1 && c <= 33));
            check("A.rd", c, char_rd, (c == 1));
            step();
        end

        // Space: 4-unit word gap, key never asserted
        fifo_q.push_back(8'd32);
        drive_fifo();
        for (int c = 0; c <= 20; c++) begin
            check("SP.key", c, key, 1'b0);
            check("SP.busy", c, busy, (c >= 1 && c <= 17));
            check("SP.rd", c, char_rd, (c == 1));
            step();
        end

        // "EE" back to back
        fifo_q.push_back(8'd69);
        fifo_q.push_back(8'd69);
        drive_fifo();
        for (int c = 0; c <= 38; c++) begin
            check("EE.key", c, key, ((c >= 2 && c <= 5) || (c >= 20 && c <= 23)));
            check("EE.busy", c, busy, ((c >= 1 && c <= 17) || (c >= 19 && c <= 35)));
            check("EE.rd", c, char_rd, (c == 1 || c == 19));
            step();
        end

        // Unsupported character: dropped after one LOOKUP cycle
        fifo_q.push_back(8'd35);
        drive_fifo();
        for (int c = 0; c <= 5; c++) begin
            check("UNS.key", c, key, 1'b0);
            check("UNS.busy", c, busy, (c == 1));
            check("UNS.rd", c, char_rd, (c == 1));
            step();
        end

        // 'T' dash aborted in its sixth cycle
        fifo_q.push_back(8'd84);
        drive_fifo();
        for (int c = 0; c <= 14; c++) begin
            abort = (c == 7);
            check("ABT.key", c, key, (c >= 2 && c <= 7));
            check("ABT.busy", c, busy, (c >= 1 && c <= 7));
            check("ABT.rd", c, char_rd, (c == 1));
            step();
        end
        abort = 1'b0;

        // 'T' dash cut by reset in its sixth cycle
        fifo_q.push_back(8'd84);
        drive_fifo();
        for (int c = 0; c <= 14; c++) begin
            rst = (c != 7);
            check("RST.key", c, key, (c >= 2 && c <= 7));
            check("RST.busy", c, busy, (c >= 1 && c <= 7));
            check("RST.rd", c, char_rd, (c == 1));
            step();
        end
        rst = 1'b1;

        // Recovery: 'E' again after reset
        fifo_q.push_back(8'd69);
        drive_fifo();
        for (int c = 0; c <= 19; c++) begin
            check("E2.key", c, key, (c >= 2 && c <= 5));
            check("E2.busy", c, busy, (c >= 1 && c <= 17));
            check("E2.rd", c, char_rd, (c == 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
